// File: rtl/digi_logic_pkg.sv
// -----------------------------------------------------------------------------
// digi_logic_pkg
// Shared definitions for the digi_logic_unit slice:
//   - opcode encodings accepted on in_op
//   - generator FSM state type
//   - default Galois LFSR feedback mask
// Optional feature macro used by the slice: DIGI_LOGIC_STATS_EN
// -----------------------------------------------------------------------------
package digi_logic_pkg;

    localparam logic [3:0] OP_AND    = 4'h0;
    localparam logic [3:0] OP_OR     = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_NAND   = 4'h3;
    localparam logic [3:0] OP_NOR    = 4'h4;
    localparam logic [3:0] OP_XNOR   = 4'h5;
    localparam logic [3:0] OP_NOTA   = 4'h6;
    localparam logic [3:0] OP_PASSA  = 4'h7;
    localparam logic [3:0] OP_ADD    = 4'h8;
    localparam logic [3:0] OP_SUB    = 4'h9;
    localparam logic [3:0] OP_POPCNT = 4'hA;
    // 0xB and 0xF are illegal encodings.
    localparam logic [3:0] OP_LFSR   = 4'hC;
    localparam logic [3:0] OP_COUNT  = 4'hD;
    // Only legal when DIGI_LOGIC_STATS_EN is defined.
    localparam logic [3:0] OP_STATS  = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_LFSR  = 2'd2
    } state_e;

    localparam logic [7:0] LFSR_POLY_DEFAULT = 8'hB8;

endpackage

// File: rtl/digi_logic_fifo.sv
// -----------------------------------------------------------------------------
// digi_logic_fifo
// Show-ahead result FIFO, W bits x DEPTH entries (DEPTH a power of two).
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset (flushes contents)
//   push, wdata     write request; ignored when full, even with a same-cycle pop
//   pop             read request; ignored when empty
//   rdata           head entry (valid whenever !empty)
//   full, empty     occupancy flags
//   count           current number of entries (0..DEPTH)
// -----------------------------------------------------------------------------
module digi_logic_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // DEPTH is a power of two, so the count MSB alone marks "full".
    assign full    = count_q[AW];
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/digi_logic_unit.sv
// -----------------------------------------------------------------------------
// digi_logic_unit
// One operation per in_valid/in_ready handshake on two WIDTH-bit operands.
// Bitwise/arithmetic ops push a single result on the accept edge; COUNT and
// LFSR ops run a small FSM that emits one value per enabled, non-full cycle.
// Every result goes through a DEPTH-entry show-ahead FIFO.
// Optional macro DIGI_LOGIC_STATS_EN: adds a 16-bit saturating push counter
// readable through op 0xE (otherwise 0xE is illegal).
// Ports:
//   clk, rst_n                  clock / asynchronous active-low reset
//   ena                         enable; low blocks accepts and freezes generators
//   in_valid, in_ready          op request handshake
//   in_op, in_a, in_b           opcode and operands
//   out_valid, out_ready        result handshake (FIFO head)
//   out_data, out_flag          result value and carry/borrow/last/illegal flag
//   busy                        a generator op is in progress
// -----------------------------------------------------------------------------
module digi_logic_unit
    import digi_logic_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(LFSR_POLY_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_flag,
    output logic             busy
);

    localparam int               CW    = $clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;   // current count value / LFSR state
    logic [WIDTH-1:0] lim_q, lim_d;   // COUNT end value / LFSR values remaining
    logic             accept;
    logic             gen_ok;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             push_flag;
    logic [WIDTH-1:0] alu_data;
    logic             alu_flag;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

`ifdef DIGI_LOGIC_STATS_EN
    logic [15:0] stats_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           stats_q <= '0;
        else if (push && stats_q != 16'hFFFF) stats_q <= stats_q + 16'd1;
    end
`endif

    function automatic logic [WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + WIDTH'(v[i]);
        return c;
    endfunction

    // Count MSB set means count == DEPTH (power of two).
    assign in_ready = rst_n && ena && (state_q == ST_IDLE) && !fifo_count[CW-1];
    assign accept   = in_valid && in_ready;
    assign gen_ok   = ena && !fifo_full;
    assign busy     = (state_q != ST_IDLE);

    assign sum  = {1'b0, in_a} + {1'b0, in_b};
    assign diff = {1'b0, in_a} - {1'b0, in_b};   // MSB is the borrow

    always_comb begin
        alu_data = '0;
        alu_flag = 1'b0;
        case (in_op)
            OP_AND:    alu_data = in_a & in_b;
            OP_OR:     alu_data = in_a | in_b;
            OP_XOR:    alu_data = in_a ^ in_b;
            OP_NAND:   alu_data = ~(in_a & in_b);
            OP_NOR:    alu_data = ~(in_a | in_b);
            OP_XNOR:   alu_data = ~(in_a ^ in_b);
            OP_NOTA:   alu_data = ~in_a;
            OP_PASSA:  alu_data = in_a;
            OP_ADD:    {alu_flag, alu_data} = sum;
            OP_SUB:    {alu_flag, alu_data} = diff;
            OP_POPCNT: begin
                alu_data = popcount(in_a);
                alu_flag = (in_a == '0);
            end
`ifdef DIGI_LOGIC_STATS_EN
            // Counter value before this op's own push.
            OP_STATS:  begin
                alu_data = WIDTH'(stats_q);
                alu_flag = (stats_q == 16'hFFFF);
            end
`endif
            default:   alu_flag = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        lim_d     = lim_q;
        push      = 1'b0;
        push_data = '0;
        push_flag = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_op == OP_COUNT) begin
                        state_d = ST_COUNT;
                        val_d   = in_a;
                        lim_d   = in_b;
                    end else if (in_op == OP_LFSR) begin
                        // An all-zero LFSR would lock up; seed 0 becomes 1.
                        state_d = ST_LFSR;
                        val_d   = (in_a == '0) ? ONE_W : in_a;
                        lim_d   = (in_b == '0) ? ONE_W : in_b;
                    end else begin
                        push      = 1'b1;
                        push_data = alu_data;
                        push_flag = alu_flag;
                    end
                end
            end
            ST_COUNT: begin
                if (gen_ok) begin
                    push      = 1'b1;
                    push_data = val_q;
                    push_flag = (val_q == lim_q);
                    if (val_q == lim_q) state_d = ST_IDLE;
                    else                val_d   = val_q + ONE_W;
                end
            end
            ST_LFSR: begin
                if (gen_ok) begin
                    push      = 1'b1;
                    push_data = val_q;
                    push_flag = (lim_q == ONE_W);
                    if (lim_q == ONE_W) begin
                        state_d = ST_IDLE;
                    end else begin
                        val_d = val_q[0] ? ((val_q >> 1) ^ LFSR_POLY) : (val_q >> 1);
                        lim_d = lim_q - ONE_W;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            val_q   <= '0;
            lim_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            lim_q   <= lim_d;
        end
    end

    digi_logic_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({push_flag, push_data}),
        .pop   (out_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Outputs read as zero while the FIFO is empty.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_rdata[WIDTH-1:0];
    assign out_flag  = !fifo_empty && fifo_rdata[WIDTH];

endmodule

// File: tb/tb_digi_logic_unit.sv
// -----------------------------------------------------------------------------
// tb_digi_logic_unit
// Directed scenarios followed by a randomized phase; expected results come
// from an operation-level model that produces the list of values each op
// should emit, held in a queue in emission order.
// -----------------------------------------------------------------------------
module tb_digi_logic_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_op = 4'h0;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_flag;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int pushes = 0;               // results produced since last reset
    logic [8:0] exp_q[$];         // {flag, data}

    always #5 clk = ~clk;

    digi_logic_unit #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flag  (out_flag),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_exp(input logic flag, input logic [7:0] data);
        exp_q.push_back({flag, data});
        pushes++;
    endtask

    // Operation-level reference: what values does this op produce?
    task automatic model_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        int s;
        int r;
        case (op)
            4'h0: add_exp(1'b0, a & b);
            4'h1: add_exp(1'b0, a | b);
            4'h2: add_exp(1'b0, a ^ b);
            4'h3: add_exp(1'b0, ~(a & b));
            4'h4: add_exp(1'b0, ~(a | b));
            4'h5: add_exp(1'b0, ~(a ^ b));
            4'h6: add_exp(1'b0, ~a);
            4'h7: add_exp(1'b0, a);
            4'h8: begin
                r = int'(a) + int'(b);
                add_exp(r > 255, 8'(r));
            end
            4'h9: add_exp(a < b, 8'(int'(a) - int'(b) + 256));
            4'hA: add_exp(a == 0, 8'($countones(a)));
            4'hC: begin
                s = (a == 0) ? 1 : int'(a);
                n = (b == 0) ? 1 : int'(b);
                for (int i = 0; i < n; i++) begin
                    add_exp(i == n - 1, 8'(s));
                    s = (s % 2 == 1) ? ((s / 2) ^ 'hB8) : (s / 2);
                end
            end
            4'hD: begin
                n = ((int'(b) - int'(a) + 256) % 256) + 1;
                for (int i = 0; i < n; i++) add_exp(i == n - 1, 8'((int'(a) + i) % 256));
            end
`ifdef DIGI_LOGIC_STATS_EN
            4'hE: add_exp(pushes >= 65535, 8'(pushes % 256));
`endif
            default: add_exp(1'b1, 8'h00);
        endcase
    endtask

    // Called at negedge+1; returns at negedge+1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int t;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        #1;
        t = 0;
        while (!in_ready && t < 1000) begin
            @(negedge clk); #1; t++;
        end
        if (!in_ready) check_eq("issue_timeout", 0, 1);
        else           model_op(op, a, b);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic f);
        int t;
        t = 0;
        while (!out_valid && t < 1000) begin
            @(negedge clk); #1; t++;
        end
        check_eq({tag, "_valid"}, 32'(out_valid), 1);
        check_eq({tag, "_data"}, 32'(out_data), 32'(d));
        check_eq({tag, "_flag"}, 32'(out_flag), 32'(f));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        pushes = 0;
    endtask

    initial begin
        int issued;
        int guard;
        logic acc_pending;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_data", 32'(out_data), 0);
        check_eq("rst_out_flag", 32'(out_flag), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 1);

        // ---------------- single-result ops ----------------
        check_eq("and_pre_valid", 32'(out_valid), 0);
        issue(4'h0, 8'hF0, 8'h3C);
        pop_check("and", 8'h30, 1'b0);   // valid right after accept edge
        issue(4'h4, 8'h00, 8'h00);  pop_check("nor", 8'hFF, 1'b0);
        issue(4'h8, 8'hFF, 8'h02);  pop_check("add", 8'h01, 1'b1);
        issue(4'h9, 8'h00, 8'h01);  pop_check("sub", 8'hFF, 1'b1);
        issue(4'hA, 8'hB7, 8'h00);  pop_check("popcnt", 8'h06, 1'b0);
        issue(4'hF, 8'h12, 8'h34);  pop_check("illegal_f", 8'h00, 1'b1);
        issue(4'hB, 8'h12, 8'h34);  pop_check("illegal_b", 8'h00, 1'b1);

        // ---------------- COUNT with backpressure ----------------
        issue(4'hD, 8'h10, 8'h17);
        repeat (8) @(negedge clk);
        #1;
        check_eq("cnt_stall_in_ready", 32'(in_ready), 0);
        check_eq("cnt_stall_busy", 32'(busy), 1);
        for (int i = 0; i < 8; i++) pop_check($sformatf("cnt%0d", i), 8'(8'h10 + i), i == 7);
        check_eq("cnt_done_busy", 32'(busy), 0);
        check_eq("cnt_done_valid", 32'(out_valid), 0);

        issue(4'hD, 8'hFE, 8'h01);
        pop_check("wrap0", 8'hFE, 1'b0);
        pop_check("wrap1", 8'hFF, 1'b0);
        pop_check("wrap2", 8'h00, 1'b0);
        pop_check("wrap3", 8'h01, 1'b1);

        // ---------------- LFSR ----------------
        issue(4'hC, 8'h00, 8'h03);
        pop_check("lfsr0", 8'h01, 1'b0);
        pop_check("lfsr1", 8'hB8, 1'b0);
        pop_check("lfsr2", 8'h5C, 1'b1);

        // ---------------- reset mid-COUNT ----------------
        issue(4'hD, 8'h00, 8'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(out_valid), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        exp_q.delete();
        pushes = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("midrst_in_ready", 32'(in_ready), 1);
        repeat (5) @(negedge clk);
        #1;
        check_eq("midrst_no_stray", 32'(out_valid), 0);
        check_eq("midrst_idle", 32'(busy), 0);

        // ---------------- stats op ----------------
        issue(4'h0, 8'hAA, 8'h0F);  pop_check("st_and", 8'h0A, 1'b0);
        issue(4'h1, 8'hA0, 8'h05);  pop_check("st_or", 8'hA5, 1'b0);
        issue(4'h2, 8'hFF, 8'h0F);  pop_check("st_xor", 8'hF0, 1'b0);
        issue(4'hE, 8'h00, 8'h00);
`ifdef DIGI_LOGIC_STATS_EN
        pop_check("stats", 8'h03, 1'b0);
`else
        pop_check("stats_illegal", 8'h00, 1'b1);
`endif

        // ---------------- randomized phase ----------------
        issued = 0;
        guard = 0;
        acc_pending = 1'b0;
        while ((issued < 150 || in_valid || exp_q.size() != 0 || busy) && guard < 30000) begin
            @(negedge clk);
            guard++;
            ena = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if (acc_pending) begin
                in_valid = 1'b0;
                acc_pending = 1'b0;
            end
            if (!in_valid && issued < 150) begin
                op = 4'($urandom_range(0, 15));
                a = 8'($urandom);
                b = 8'($urandom);
                if (op == 4'hD) b = 8'(a + 8'($urandom_range(0, 9)));
                if (op == 4'hC) b = 8'($urandom_range(0, 6));
                in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rnd_unexpected", {23'd0, out_flag, out_data}, 32'h1FF_FFFF);
                end else begin
                    check_eq("rnd_result", {23'd0, out_flag, out_data}, {23'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                model_op(in_op, in_a, in_b);
                issued++;
                acc_pending = 1'b1;
            end
        end
        check_eq("rnd_timeout", 32'(guard < 30000), 1);
        check_eq("rnd_leftover", 32'(exp_q.size()), 0);
        check_eq("rnd_final_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
